// File: rtl/fetch_unit.sv
// Instruction-fetch stage with PC, internal instruction memory and IF/ID register.
// Detects load-use hazards against the EX stage and stalls; flushes IF/ID on redirect.
module fetch_unit #(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'd100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        em2reg,
  input  logic        ewreg,
  input  logic [4:0]  edestReg,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        imem_we,
  input  logic [31:0] imem_waddr,
  input  logic [31:0] imem_wdata,
  output logic [31:0] pc,
  output logic [31:0] dinstOut,
  output logic [31:0] dpc4,
  output logic        bubble,
  output logic [15:0] stall_cnt
);

  localparam int          AW      = $clog2(IMEM_DEPTH);
  localparam logic [29:0] DEPTH_W = 30'(IMEM_DEPTH);

  logic [31:0]   imem [IMEM_DEPTH];
  logic [31:0]   fetch_word;
  logic [5:0]    op;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic          hz;
  logic          fetch_in_range;
  logic          write_in_range;
  logic [AW-1:0] fetch_idx;
  logic [AW-1:0] write_idx;
  logic [1:0]    unused_waddr_lsb;

  assign op               = dinstOut[31:26];
  assign rs               = dinstOut[25:21];
  assign rt               = dinstOut[20:16];
  assign fetch_in_range   = (pc[31:2] < DEPTH_W);
  assign write_in_range   = (imem_waddr[31:2] < DEPTH_W);
  assign fetch_idx        = pc[AW+1:2];
  assign write_idx        = imem_waddr[AW+1:2];
  assign unused_waddr_lsb = imem_waddr[1:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    fetch_word = 32'h0;
    if (fetch_in_range) fetch_word = imem[fetch_idx];
  end

  always_comb begin
    hz = em2reg & ewreg & (edestReg != 5'd0) &
         ((edestReg == rs) | ((op == 6'd0) & (edestReg == rt)));
    bubble = hz & ~redirect & ~rst;
  end

  // NOTE: the instruction array has no reset; program contents survive rst and the
  // array can map onto plain RAM. A same-cycle write/fetch sees the old word.
  always_ff @(posedge clk) begin
    if (imem_we && write_in_range) imem[write_idx] <= imem_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      dinstOut  <= 32'h0;
      dpc4      <= 32'h0;
      stall_cnt <= 16'h0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      dinstOut <= 32'h0;
      dpc4     <= 32'h0;
    end else if (hz) begin
      if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end else begin
      dinstOut <= fetch_word;
      dpc4     <= pc + 32'd4;
      pc       <= pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: expected register states are queued when
// stimulus is applied and popped/compared after the clock edge that produces them.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        em2reg;
  logic        ewreg;
  logic [4:0]  edestReg;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] pc;
  logic [31:0] dinstOut;
  logic [31:0] dpc4;
  logic        bubble;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] dinst;
    logic [31:0] dpc4;
    logic [15:0] stall;
  } exp_t;

  exp_t sb[$];

  fetch_unit #(.IMEM_DEPTH(64), .RESET_PC(32'd100)) dut (
    .clk(clk), .rst(rst), .em2reg(em2reg), .ewreg(ewreg), .edestReg(edestReg),
    .redirect(redirect), .redirect_pc(redirect_pc), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .pc(pc), .dinstOut(dinstOut),
    .dpc4(dpc4), .bubble(bubble), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    imem_we    = 1'b1;
    imem_waddr = addr;
    imem_wdata = data;
    @(posedge clk);
    #1;
    imem_we = 1'b0;
  endtask

  task automatic set_ex(input logic load, input logic [4:0] dest);
    em2reg   = load;
    ewreg    = load;
    edestReg = dest;
  endtask

  // Queue the state expected after the next edge, clock it, then pop and compare.
  task automatic step(input string tag, input logic [31:0] e_pc, input logic [31:0] e_dinst,
                      input logic [31:0] e_dpc4, input logic [15:0] e_stall);
    exp_t e;
    sb.push_back('{tag, e_pc, e_dinst, e_dpc4, e_stall});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".pc"}, pc, e.pc);
    check({e.tag, ".dinst"}, dinstOut, e.dinst);
    check({e.tag, ".dpc4"}, dpc4, e.dpc4);
    check({e.tag, ".stall"}, {16'h0, stall_cnt}, {16'h0, e.stall});
  endtask

  task automatic check_bubble(input string tag, input logic exp);
    #1;
    check(tag, {31'h0, bubble}, {31'h0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    imem_we = 1'b0; imem_waddr = 32'h0; imem_wdata = 32'h0;
    set_ex(1'b0, 5'd0);

    // Program loaded while reset is held (well over two cycles).
    write_word(32'd100, 32'h8C010000);  // lw  r1,0(r0)
    write_word(32'd104, 32'h00221820);  // add r3,r1,r2
    write_word(32'd108, 32'hAC030004);  // sw  r3,4(r0)
    write_word(32'd112, 32'h8C450000);  // lw  r5,0(r2)
    write_word(32'd116, 32'h00A61020);  // add r2,r5,r6
    write_word(32'd120, 32'h20420001);  // addi r2,r2,1
    write_word(32'd0,   32'h00622020);  // add r4,r3,r2

    check("rst.pc", pc, 32'd100);
    check("rst.dinst", dinstOut, 32'h0);
    check("rst.dpc4", dpc4, 32'h0);
    check("rst.stall", {16'h0, stall_cnt}, 32'h0);
    check_bubble("rst.bubble", 1'b0);

    rst = 1'b0;
    step("fetch0", 32'd104, 32'h8C010000, 32'd104, 16'd0);

    // Load in EX with destination r0: rs of the held word is also 0, but no stall.
    set_ex(1'b1, 5'd0);
    check_bubble("nostallA.bubble", 1'b0);
    step("nostallA", 32'd108, 32'h00221820, 32'd108, 16'd0);

    // Load-use on rt of an R-type word.
    set_ex(1'b1, 5'd2);
    check_bubble("stall.bubble", 1'b1);
    step("stall", 32'd108, 32'h00221820, 32'd108, 16'd1);

    set_ex(1'b0, 5'd2);
    check_bubble("resume.bubble", 1'b0);
    step("resume", 32'd112, 32'hAC030004, 32'd112, 16'd1);
    step("seq", 32'd116, 32'h8C450000, 32'd116, 16'd1);

    // Non-R-type (op 0x23): matching only rt must not stall.
    set_ex(1'b1, 5'd5);
    check_bubble("nostallB.bubble", 1'b0);
    step("nostallB", 32'd120, 32'h00A61020, 32'd120, 16'd1);

    // Hazard and redirect together: redirect wins, hazard dropped.
    set_ex(1'b1, 5'd6);
    check_bubble("hz_rt.bubble", 1'b1);
    redirect = 1'b1; redirect_pc = 32'd120;
    check_bubble("redir.bubble", 1'b0);
    step("redir", 32'd120, 32'h0, 32'h0, 16'd1);

    // Target word arrives on the second edge; a same-cycle write returns old contents.
    redirect = 1'b0; set_ex(1'b0, 5'd0);
    imem_we = 1'b1; imem_waddr = 32'd122; imem_wdata = 32'hDEADBEEF;
    step("target", 32'd124, 32'h20420001, 32'd124, 16'd1);
    imem_we = 1'b0;

    redirect = 1'b1; redirect_pc = 32'd400;
    step("redir400", 32'd400, 32'h0, 32'h0, 16'd1);
    redirect = 1'b0;
    step("oor", 32'd404, 32'h0, 32'd404, 16'd1);

    redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
    step("redirtop", 32'hFFFFFFFC, 32'h0, 32'h0, 16'd1);
    redirect = 1'b0;
    step("wrap", 32'h0, 32'h0, 32'h0, 16'd1);
    step("fetchw0", 32'd4, 32'h00622020, 32'd4, 16'd1);

    // Back-to-back stall, then reset while the hazard is still present.
    set_ex(1'b1, 5'd3);
    check_bubble("stall2.bubble", 1'b1);
    step("stall2", 32'd4, 32'h00622020, 32'd4, 16'd2);
    check_bubble("stall3.bubble", 1'b1);
    rst = 1'b1;
    check_bubble("rststall.bubble", 1'b0);
    step("rststall", 32'd100, 32'h0, 32'h0, 16'd0);

    // Memory survives reset.
    rst = 1'b0; set_ex(1'b0, 5'd0);
    step("postrst", 32'd104, 32'h8C010000, 32'd104, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage and IF/ID pipeline register of the five-stage pipeline. It holds the program counter and an internal instruction memory, and registers the fetched word into `dinstOut` for decode. It also detects load-use hazards against the EX-stage controls (`em2reg`, `edestReg`) and stalls. On a redirect from a resolved branch/jump it flushes the IF/ID register.

## Interface

Parameters:

- `IMEM_DEPTH`, default 64: instruction memory depth in 32-bit words; must be a power of two.
- `RESET_PC`, default 32'd100: PC value loaded by reset; word-aligned.

Ports:

- `clk` — input, 1: clock; all state updates on the rising edge.
- `rst` — input, 1: reset, synchronous, active-high.
- `em2reg` — input, 1: EX-stage instruction is a load.
- `ewreg` — input, 1: EX-stage instruction writes the register file.
- `edestReg` — input, 5: EX-stage destination register.
- `redirect` — input, 1: taken branch/jump; replace next PC.
- `redirect_pc` — input, 32: redirect target, word-aligned.
- `imem_we` — input, 1: instruction-memory write enable (bench/loader).
- `imem_waddr` — input, 32: byte address of the write; bits [1:0] ignored.
- `imem_wdata` — input, 32: instruction word to write.
- `pc` — output, 32: current fetch PC (register).
- `dinstOut` — output, 32: IF/ID instruction register.
- `dpc4` — output, 32: IF/ID register holding fetch PC + 4.
- `bubble` — output, 1: combinational; decode must send a NOP into EX this cycle.
- `stall_cnt` — output, 16: number of stall cycles since reset, saturating.

## Operation

- Memory index: `pc[log2(IMEM_DEPTH)+1:2]` when `pc[31:2] < IMEM_DEPTH`. Outside that range the fetched word is 32'h0 (NOP).
- Memory writes are synchronous. A write and a fetch to the same word in the same cycle returns the old contents.
- Memory contents are not cleared by `rst`.
- Decode fields of `dinstOut`: `op = [31:26]`, `rs = [25:21]`, `rt = [20:16]`.
- Hazard condition: `hz = em2reg & ewreg & (edestReg != 0) & (edestReg == rs | (op == 0 & edestReg == rt))`.
- Priority each cycle is rst > redirect > hz > normal.
  - **rst:** `pc` ← RESET_PC; `dinstOut` ← 0; `dpc4` ← 0; `stall_cnt` ← 0.
  - **redirect:**
    - `pc` ← `redirect_pc`.
    - `dinstOut` ← 0 (flush).
    - `dpc4` ← 0.
    - The pending hazard is dropped.
  - **hz:**
    - `pc`, `dinstOut` and `dpc4` hold.
    - `stall_cnt` increments unless it is 16'hFFFF.
  - **normal:**
    - `dinstOut` ← imem[pc].
    - `dpc4` ← `pc` + 4.
    - `pc` ← `pc` + 4, modulo 2^32 (wraps 32'hFFFFFFFC → 0).
- `bubble = hz & ~redirect & ~rst`.
- Because the EX stage receives a bubble, `em2reg` falls the next cycle, so a single load-use hazard stalls exactly one cycle.
- Back-to-back hazards (a new load in EX matching the held instruction) stall again; the counter counts each cycle.

## Timing

- Reset values of every output:
  - `pc` = RESET_PC
  - `dinstOut` = 0
  - `dpc4` = 0
  - `stall_cnt` = 0
  - `bubble` = 0 while `rst` is high.
- Fetch latency: the word at `pc` appears on `dinstOut` one edge later.
- After `rst` falls, the first edge gives `dinstOut` = imem[RESET_PC] and `pc` = RESET_PC+4.
- Redirect latency: one edge. The cycle after `redirect` shows `pc` = target and `dinstOut` = 0. The target word reaches `dinstOut` on the second edge.
- `bubble` is combinational from `dinstOut` and the EX inputs. It is valid in the same cycle and carries no registered delay.
- `rst` asserted mid-stall or mid-redirect overrides everything at that edge.

## Test plan

- **Reset and sequential fetch.**
  - Stimulus: load imem[25..27] = 32'h8C010000, 32'h00221820, 32'hAC030004; hold `rst` for 2 cycles, then release.
  - Required: `pc` = 100 during reset; then `dinstOut` = 32'h8C010000 with `pc` = 104, then 32'h00221820 with `pc` = 108.
- **Load-use stall.**
  - Stimulus: `dinstOut` = 32'h00221820 (rs = 1, rt = 2), `em2reg` = `ewreg` = 1, `edestReg` = 2.
  - Required: `bubble` = 1; `pc` and `dinstOut` hold one edge; `stall_cnt` = 1. Next cycle with `em2reg` = 0, fetch resumes.
- **No stall cases.**
  - Stimulus A: `edestReg` = 0. Stimulus B: `op` = 6'h23 with `edestReg` == rt only.
  - Required: `bubble` = 0 and `pc` advances in both cases.
- **Redirect vs stall.**
  - Stimulus: hazard active and `redirect` = 1, `redirect_pc` = 32'd120 in the same cycle.
  - Required: `bubble` = 0; next cycle `pc` = 120, `dinstOut` = 0, `stall_cnt` unchanged.
- **Out-of-range fetch and wrap.**
  - Stimulus: redirect to 32'd400 (word 100 ≥ 64).
  - Required: `dinstOut` = 0.
  - Stimulus: redirect to 32'hFFFFFFFC.
  - Required: next `pc` = 0.
- **Reset mid-stall.**
  - Stimulus: assert `rst` while `bubble` = 1.
  - Required: next edge gives `pc` = 100, `dinstOut` = 0, `stall_cnt` = 0.
